// File: rtl/dbus_sram_responder.sv
// Data-bus responder backed by a word-addressed 64-bit SRAM.
// Answers each captured request after a fixed LATENCY, with byte-strobe
// writes and a natural-alignment check on the request size.

package dbus_pkg;

  typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

endpackage

module dbus_sram_responder
  import dbus_pkg::*;
#(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned WORDS   = 1024,
  localparam int unsigned IDX_W  = $clog2(WORDS)
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       misalign
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  localparam logic [3:0] CntInit = 4'(LATENCY - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              capture;
  logic [IDX_W+2:0]  addr_q;
  msize_t            size_q;
  logic [7:0]        strobe_q;
  logic [63:0]       data_q;

  logic [63:0]       mem [WORDS];
  logic [IDX_W-1:0]  idx;
  logic [63:0]       rd_word;
  logic              in_resp;
  logic              bad_align;
  logic              we;

  // Upper address bits alias onto the array and are deliberately dropped.
  logic unused_addr;
  assign unused_addr = ^dreq.addr[31:IDX_W+3];

  // State, counter and captured request; reset drops any in-flight transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      addr_q   <= '0;
      size_q   <= MSIZE1;
      strobe_q <= '0;
      data_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        addr_q   <= dreq.addr[IDX_W+2:0];
        size_q   <= dreq.size;
        strobe_q <= dreq.strobe;
        data_q   <= dreq.data;
      end
    end
  end

  // Next-state logic: IDLE captures, WAIT counts down to 1, RESP lasts one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (dreq.valid) begin
          capture = 1'b1;
          cnt_d   = CntInit;
          state_d = (LATENCY == 1) ? StResp : StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Alignment check on the captured size and low address bits.
  always_comb begin
    bad_align = 1'b0;
    unique case (size_q)
      MSIZE1:  bad_align = 1'b0;
      MSIZE2:  bad_align = addr_q[0];
      MSIZE4:  bad_align = |addr_q[1:0];
      MSIZE8:  bad_align = |addr_q[2:0];
      default: bad_align = 1'b0;
    endcase
  end

  assign idx     = addr_q[IDX_W+2:3];
  assign rd_word = mem[idx];
  // Gating with reset keeps a RESP cycle that is being reset silent.
  assign in_resp = (state_q == StResp) && !reset;
  assign we      = in_resp && !bad_align && (|strobe_q);

  // Response outputs are zero outside RESP; read data is pre-write contents.
  always_comb begin
    dresp    = '0;
    misalign = 1'b0;
    if (in_resp) begin
      dresp.addr_ok = 1'b1;
      dresp.data_ok = 1'b1;
      dresp.data    = bad_align ? 64'd0 : rd_word;
      misalign      = bad_align;
    end
  end

  // Byte-strobed write committed at the edge that ends RESP; array is not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 8; i++) begin
        if (strobe_q[i]) mem[idx][8*i +: 8] <= data_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Directed bench: four responders with LATENCY 2, 1, 5 and 4 share one clock.
module tb_dbus_sram_responder;
  import dbus_pkg::*;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst [N];
  dbus_req_t  req [N];
  dbus_resp_t resp [N];
  logic       mis [N];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int unsigned L = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 5 : 4;
    dbus_sram_responder #(
      .LATENCY(L),
      .WORDS  (1024)
    ) u_dut (
      .clk     (clk),
      .reset   (rst[g]),
      .dreq    (req[g]),
      .dresp   (resp[g]),
      .misalign(mis[g])
    );
  end

  // Drives one request held until data_ok, then drops valid and waits out RESP.
  // Entered and left at 1 time unit after a rising edge.
  task automatic txn(input int d, input logic [31:0] a, input msize_t s,
                     input logic [7:0] st, input logic [63:0] wd,
                     output int lat, output logic [63:0] rd, output logic m);
    req[d] = '{valid: 1'b1, addr: a, size: s, strobe: st, data: wd};
    @(posedge clk); #1;
    lat = 1;
    while (!resp[d].data_ok && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = resp[d].data;
    m  = mis[d];
    req[d].valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b1;
      req[i] = '0;
    end
    @(posedge clk); @(posedge clk); #1;
    for (int i = 0; i < N; i++) rst[i] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < N; i++) begin
        total++;
        if ({resp[i].addr_ok, resp[i].data_ok, resp[i].data, mis[i]} !== 67'd0) begin
          $display("FAIL reset_idle dut%0d cyc%0d: got ok=%b%b data=%h mis=%b want all zero",
                   i, c, resp[i].addr_ok, resp[i].data_ok, resp[i].data, mis[i]);
        end else passed++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_write_read();
    int lat; logic [63:0] rd; logic m;
    txn(0, 32'h8000_0010, MSIZE8, 8'hFF, 64'h1122_3344_5566_7788, lat, rd, m);
    total++;
    if (lat !== 2) $display("FAIL wr_latency: got %0d want 2", lat); else passed++;
    total++;
    if (m !== 1'b0) $display("FAIL wr_misalign: got %b want 0", m); else passed++;
    txn(0, 32'h8000_0010, MSIZE8, 8'h00, 64'h0, lat, rd, m);
    total++;
    if (lat !== 2) $display("FAIL rd_latency: got %0d want 2", lat); else passed++;
    total++;
    if (rd !== 64'h1122_3344_5566_7788)
      $display("FAIL rd_data: got %h want 1122334455667788", rd);
    else passed++;
  endtask

  task automatic test_strobe();
    int lat; logic [63:0] rd; logic m;
    txn(0, 32'h8000_0010, MSIZE8, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB, lat, rd, m);
    total++;
    if (rd !== 64'h1122_3344_5566_7788)
      $display("FAIL strobe_old_data: got %h want 1122334455667788", rd);
    else passed++;
    txn(0, 32'h8000_0010, MSIZE8, 8'h00, 64'h0, lat, rd, m);
    total++;
    if (rd !== 64'h1122_3344_BBBB_BBBB)
      $display("FAIL strobe_merge: got %h want 11223344bbbbbbbb", rd);
    else passed++;
  endtask

  task automatic test_misalign();
    int lat; logic [63:0] rd; logic m;
    txn(0, 32'h8000_0012, MSIZE4, 8'h3C, 64'h5555_5555_5555_5555, lat, rd, m);
    total++;
    if (lat !== 2) $display("FAIL mis_latency: got %0d want 2", lat); else passed++;
    total++;
    if (m !== 1'b1) $display("FAIL mis_flag: got %b want 1", m); else passed++;
    total++;
    if (rd !== 64'd0) $display("FAIL mis_data: got %h want 0", rd); else passed++;
    txn(0, 32'h8000_0010, MSIZE8, 8'h00, 64'h0, lat, rd, m);
    total++;
    if (rd !== 64'h1122_3344_BBBB_BBBB)
      $display("FAIL mis_unchanged: got %h want 11223344bbbbbbbb", rd);
    else passed++;
    total++;
    if (m !== 1'b0) $display("FAIL mis_clear: got %b want 0", m); else passed++;
  endtask

  task automatic test_alias(input int d, input int l);
    int lat; logic [63:0] rd; logic m;
    txn(d, 32'h0000_0000, MSIZE8, 8'hFF, 64'hDEAD, lat, rd, m);
    total++;
    if (lat !== l) $display("FAIL alias_wr_lat dut%0d: got %0d want %0d", d, lat, l);
    else passed++;
    txn(d, 32'h0000_2000, MSIZE8, 8'h00, 64'h0, lat, rd, m);
    total++;
    if (lat !== l) $display("FAIL alias_rd_lat dut%0d: got %0d want %0d", d, lat, l);
    else passed++;
    total++;
    if (rd !== 64'hDEAD) $display("FAIL alias_data dut%0d: got %h want dead", d, rd);
    else passed++;
  endtask

  // Valid held continuously: pulses expected at cycles l and 2l+1 only.
  task automatic test_back_to_back(input int d, input int l);
    logic exp_ok;
    req[d] = '{valid: 1'b1, addr: 32'h0, size: MSIZE8, strobe: 8'h00, data: 64'h0};
    @(posedge clk);
    for (int c = 1; c <= 2 * l + 2; c++) begin
      #1;
      exp_ok = (c == l) || (c == 2 * l + 1);
      total++;
      if (resp[d].data_ok !== exp_ok)
        $display("FAIL b2b_ok dut%0d cyc%0d: got %b want %b", d, c, resp[d].data_ok, exp_ok);
      else passed++;
      if (exp_ok) begin
        total++;
        if (resp[d].data !== 64'hDEAD)
          $display("FAIL b2b_data dut%0d cyc%0d: got %h want dead", d, c, resp[d].data);
        else passed++;
      end
      if (c == 2 * l + 1) req[d].valid = 1'b0;
      @(posedge clk);
    end
    #1;
  endtask

  task automatic test_reset_midop();
    int lat; logic [63:0] rd; logic m;
    txn(3, 32'h0000_0040, MSIZE8, 8'hFF, 64'h0123_4567_89AB_CDEF, lat, rd, m);
    total++;
    if (lat !== 4) $display("FAIL midop_pre_lat: got %0d want 4", lat); else passed++;
    req[3] = '{valid: 1'b1, addr: 32'h40, size: MSIZE8, strobe: 8'hFF, data: 64'hFFFF_FFFF_FFFF_FFFF};
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst[3]       = 1'b1;
    req[3].valid = 1'b0;
    @(posedge clk); #1;
    rst[3] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      total++;
      if (resp[3].data_ok !== 1'b0)
        $display("FAIL midop_no_ok cyc%0d: got %b want 0", c, resp[3].data_ok);
      else passed++;
      @(posedge clk); #1;
    end
    txn(3, 32'h0000_0040, MSIZE8, 8'h00, 64'h0, lat, rd, m);
    total++;
    if (rd !== 64'h0123_4567_89AB_CDEF)
      $display("FAIL midop_old_data: got %h want 0123456789abcdef", rd);
    else passed++;
    total++;
    if (lat !== 4) $display("FAIL midop_post_lat: got %0d want 4", lat); else passed++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_strobe();
    test_misalign();
    test_alias(1, 1);
    test_alias(2, 5);
    test_back_to_back(1, 1);
    test_back_to_back(2, 5);
    test_reset_midop();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
